data_refill_buf: RTL and testbench
==================================

# data_refill_buf

Refill assembly buffer that sits directly upstream of the cache data array write port. It collects 64-bit refill beats from the memory side for up to ENTRIES outstanding line fills, each tagged by transaction ID. It writes each completed 128-bit half-line into the data array with the matching half mask, and signals line completion back to the miss-handling logic.

## Interface
- SET_W, 6, set index width; matches the data array `w_set`
- WAY_W, 2, way index width; matches `w_way`
- ID_W, 3, refill transaction ID width
- ENTRIES, 2, fill entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  new fill request
- req_ready  out  1  request accepted this cycle
- req_id  in  ID_W  fill transaction ID
- req_set  in  SET_W  target set
- req_way  in  WAY_W  target way
- beat_valid  in  1  refill beat present
- beat_ready  out  1  beat consumed this cycle
- beat_id  in  ID_W  beat transaction ID
- beat_data  in  64  beat payload; beats are in ascending order 0..3 per ID
- wr_stall  in  1  data array write port unavailable this cycle
- w_en  out  1  data array write strobe
- w_set  out  SET_W  write set
- w_way  out  WAY_W  write way
- w_mask  out  2  bit0 = bits 127:0, bit1 = bits 255:128
- w_data  out  256  write data; unmasked lanes driven 0
- done_valid  out  1  one-cycle pulse, line fully written
- done_id  out  ID_W  ID of completed line
- err_beat  out  1  one-cycle pulse, beat dropped
- free_cnt  out  $clog2(ENTRIES)+1  number of IDLE entries

## Operation
- Per-entry state: IDLE or FILL. Also held per entry: id, set, way, 256-bit line buffer, 3-bit beat count (0..4), lo_pend, hi_pend, lo_done, hi_done.
- Allocation:
  - req_ready = (some entry IDLE) && (no FILL entry with id == req_id) && !rst.
  - On handshake, the lowest-index IDLE entry goes to FILL. Its count and all flags clear.
- Beat acceptance:
  - beat_ready = 1 always, except during rst.
  - A beat matches the FILL entry with the same id and count < 4. It is written at lanes [64*count+63 : 64*count], and count increments.
  - When count goes 1→2, lo_pend sets. When count goes 3→4, hi_pend sets.
  - A beat with no matching entry is dropped: no state change, err_beat pulses the next cycle. This covers an unknown id, count == 4, and a beat arriving in the same cycle as its own req handshake.
- Write selection:
  - Candidates are entries with lo_pend or hi_pend set.
  - Selection is round-robin. The pointer advances to one past the granted entry after each issued write.
  - The granted entry drives w_set, w_way and w_data.
  - w_mask = {hi_pend, lo_pend}, so both halves merge into a single 2'b11 write when both are pending.
  - w_en = candidate exists && !wr_stall. All write outputs are 0 when w_en = 0.
  - On an issued write, the pend flags that were written clear and the corresponding done flags set.
- Completion:
  - When lo_done && hi_done, the entry returns to IDLE on the next edge.
  - done_valid/done_id pulse in that same cycle, i.e. the cycle after the final write.
  - The freed entry is allocatable the cycle after done_valid.
- Reset: all entries IDLE, RR pointer 0, no done pulses for discarded fills.

## Timing
- Reset values: req_ready 0 and beat_ready 0 while rst is high. w_en 0, w_mask 0, w_data 0, w_set 0, w_way 0, done_valid 0, done_id 0, err_beat 0. free_cnt = ENTRIES.
- Write outputs are combinational from entry registers and wr_stall. done_valid and err_beat are registered.
- Beat 1 accepted at cycle t → lo_pend set at t+1 → w_en with mask 01 at t+1 if not stalled.
- Beat 3 accepted at cycle t, with the low half already written → w_en with mask 10 at t+1 → done_valid at t+2.
- The minimum request-to-done latency is 4 beat cycles + 2.
- While wr_stall is held: pending halves accumulate, outputs stay 0, and beats continue to be accepted. An entry with all 4 beats waits.
- The same entry may receive a beat and issue a write in the same cycle. The beat updates the buffer at the edge; the issued write uses pre-edge data and flags.
- The request path and the done path are independent in the same cycle. free_cnt reflects registered state.

## Test plan
- Single fill:
  - Stimulus: req id 3, set 0x15, way 2; beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles.
  - Response: w_en mask 01 carrying beats 0/1 in bits 127:0 one cycle after beat 1. Mask 10 carrying beats 2/3 one cycle after beat 3. done_id 3 one cycle later.
- Stall merge:
  - Stimulus: hold wr_stall during all 4 beats, then release.
  - Response: exactly one write, mask 11, full 256-bit line; done_valid the next cycle.
- Interleaving:
  - Stimulus: two fills, ids 1 and 2, beats alternating, both halves pending together.
  - Response: writes granted round-robin, each set/way correct, both done pulses, free_cnt returns to 2.
- Full and duplicate requests:
  - With 2 entries busy, a third req holds req_ready 0 until the cycle after a done pulse.
  - A req reusing an active id holds req_ready 0.
- Error beats:
  - Stimulus: a beat with an unknown id, and a fifth beat for an active id.
  - Response: err_beat pulses, no write and no buffer corruption.
- Reset mid-fill:
  - Stimulus: assert rst after 2 beats.
  - Response: all outputs 0, free_cnt = ENTRIES, no done pulse. A fresh fill afterwards completes normally.

Source files
------------

// File: rtl/data_refill_buf.sv
// Refill assembly buffer: gathers 64-bit refill beats per transaction ID into
// 256-bit lines and writes completed halves into the cache data array.
module data_refill_buf #(
  parameter int unsigned SET_W   = 6,
  parameter int unsigned WAY_W   = 2,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned ENTRIES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ID_W-1:0]          req_id,
  input  logic [SET_W-1:0]         req_set,
  input  logic [WAY_W-1:0]         req_way,
  input  logic                     beat_valid,
  output logic                     beat_ready,
  input  logic [ID_W-1:0]          beat_id,
  input  logic [63:0]              beat_data,
  input  logic                     wr_stall,
  output logic                     w_en,
  output logic [SET_W-1:0]         w_set,
  output logic [WAY_W-1:0]         w_way,
  output logic [1:0]               w_mask,
  output logic [255:0]             w_data,
  output logic                     done_valid,
  output logic [ID_W-1:0]          done_id,
  output logic                     err_beat,
  output logic [$clog2(ENTRIES):0] free_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = $clog2(ENTRIES) + 1;

  typedef enum logic {IDLE, FILL} ent_state_t;

  ent_state_t         st     [ENTRIES];
  logic [ID_W-1:0]    e_id   [ENTRIES];
  logic [SET_W-1:0]   e_set  [ENTRIES];
  logic [WAY_W-1:0]   e_way  [ENTRIES];
  logic [255:0]       line   [ENTRIES];
  logic [2:0]         cnt    [ENTRIES];
  logic [ENTRIES-1:0] lo_pend, hi_pend, lo_done, hi_done;
  logic [IDX_W-1:0]   rr;

  logic [CNT_W-1:0]   free_n;
  logic               any_idle, dup_id, hit, beat_hit, cand_any;
  logic [IDX_W-1:0]   alloc_idx, hit_idx, gnt, cand;

  // Entries in FILL carry unique IDs, so at most one entry can match a beat.
  always_comb begin
    free_n    = '0;
    any_idle  = 1'b0;
    dup_id    = 1'b0;
    alloc_idx = '0;
    hit       = 1'b0;
    hit_idx   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (st[i] == IDLE) begin
        if (!any_idle) alloc_idx = IDX_W'(i);
        any_idle = 1'b1;
        free_n   = free_n + CNT_W'(1);
      end else begin
        if (e_id[i] == req_id) dup_id = 1'b1;
        if (e_id[i] == beat_id && cnt[i] < 3'd4) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    cand_any = 1'b0;
    gnt      = '0;
    cand     = '0;
    for (int unsigned k = 0; k < ENTRIES; k++) begin
      cand = rr + IDX_W'(k);
      if (!cand_any && (lo_pend[cand] || hi_pend[cand])) begin
        cand_any = 1'b1;
        gnt      = cand;
      end
    end
  end

  assign req_ready  = any_idle && !dup_id && !rst;
  assign beat_ready = !rst;
  assign beat_hit   = beat_valid && beat_ready && hit;
  assign free_cnt   = free_n;

  assign w_en   = cand_any && !wr_stall && !rst;
  assign w_mask = w_en ? {hi_pend[gnt], lo_pend[gnt]} : 2'b00;
  assign w_set  = w_en ? e_set[gnt] : '0;
  assign w_way  = w_en ? e_way[gnt] : '0;
  assign w_data = w_en ? (line[gnt] & {{128{hi_pend[gnt]}}, {128{lo_pend[gnt]}}}) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
      lo_pend    <= '0;
      hi_pend    <= '0;
      lo_done    <= '0;
      hi_done    <= '0;
      rr         <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      err_beat   <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      err_beat   <= beat_valid && !hit;

      // The write consumes pre-edge flags; a concurrent beat can only set the
      // other half's pend flag, so clear-then-set ordering is safe.
      if (w_en) begin
        rr <= gnt + IDX_W'(1);
        if (w_mask[0]) begin
          lo_pend[gnt] <= 1'b0;
          lo_done[gnt] <= 1'b1;
        end
        if (w_mask[1]) begin
          hi_pend[gnt] <= 1'b0;
          hi_done[gnt] <= 1'b1;
        end
        done_valid <= (lo_done[gnt] || w_mask[0]) && (hi_done[gnt] || w_mask[1]);
        done_id    <= e_id[gnt];
      end

      if (beat_hit) begin
        line[hit_idx][{cnt[hit_idx][1:0], 6'd0} +: 64] <= beat_data;
        cnt[hit_idx] <= cnt[hit_idx] + 3'd1;
        if (cnt[hit_idx] == 3'd1) lo_pend[hit_idx] <= 1'b1;
        if (cnt[hit_idx] == 3'd3) hi_pend[hit_idx] <= 1'b1;
      end

      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (st[i] == FILL && lo_done[i] && hi_done[i]) st[i] <= IDLE;
      end

      if (req_valid && req_ready) begin
        st[alloc_idx]      <= FILL;
        e_id[alloc_idx]    <= req_id;
        e_set[alloc_idx]   <= req_set;
        e_way[alloc_idx]   <= req_way;
        cnt[alloc_idx]     <= '0;
        lo_pend[alloc_idx] <= 1'b0;
        hi_pend[alloc_idx] <= 1'b0;
        lo_done[alloc_idx] <= 1'b0;
        hi_done[alloc_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_refill_buf.sv
// Bench for data_refill_buf: expected writes and done IDs are queued as
// stimulus is driven and popped by a negedge monitor as the DUT emits them.
`timescale 1ns/1ps
module tb_data_refill_buf;
  localparam int unsigned SET_W   = 6;
  localparam int unsigned WAY_W   = 2;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned ENTRIES = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     req_valid, req_ready;
  logic [ID_W-1:0]          req_id;
  logic [SET_W-1:0]         req_set;
  logic [WAY_W-1:0]         req_way;
  logic                     beat_valid, beat_ready;
  logic [ID_W-1:0]          beat_id;
  logic [63:0]              beat_data;
  logic                     wr_stall;
  logic                     w_en;
  logic [SET_W-1:0]         w_set;
  logic [WAY_W-1:0]         w_way;
  logic [1:0]               w_mask;
  logic [255:0]             w_data;
  logic                     done_valid;
  logic [ID_W-1:0]          done_id;
  logic                     err_beat;
  logic [$clog2(ENTRIES):0] free_cnt;

  always #5 clk = ~clk;

  data_refill_buf #(
    .SET_W(SET_W), .WAY_W(WAY_W), .ID_W(ID_W), .ENTRIES(ENTRIES)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_set(req_set), .req_way(req_way),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
    .beat_data(beat_data), .wr_stall(wr_stall),
    .w_en(w_en), .w_set(w_set), .w_way(w_way), .w_mask(w_mask), .w_data(w_data),
    .done_valid(done_valid), .done_id(done_id), .err_beat(err_beat),
    .free_cnt(free_cnt)
  );

  typedef struct packed {
    logic [SET_W-1:0] set;
    logic [WAY_W-1:0] way;
    logic [1:0]       mask;
    logic [255:0]     data;
  } wr_t;

  wr_t             wq[$];
  logic [ID_W-1:0] dq[$];
  int              checks = 0;
  int              errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    beat_valid = 1'b0;
    wr_stall   = 1'b0;
  endtask

  task automatic drive_req(input logic [ID_W-1:0] id, input logic [SET_W-1:0] s,
                           input logic [WAY_W-1:0] w);
    req_valid = 1'b1;
    req_id    = id;
    req_set   = s;
    req_way   = w;
  endtask

  task automatic drive_beat(input logic [ID_W-1:0] id, input logic [63:0] d);
    beat_valid = 1'b1;
    beat_id    = id;
    beat_data  = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic monitor();
    wr_t             e;
    logic [ID_W-1:0] eid;
    forever begin
      @(negedge clk);
      checks++;
      if (w_en === 1'b1) begin
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got set=%h way=%h mask=%b want no write", w_set, w_way, w_mask);
        end else begin
          e = wq.pop_front();
          if (w_set !== e.set || w_way !== e.way || w_mask !== e.mask || w_data !== e.data) begin
            errors++;
            $display("FAIL write got set=%h way=%h mask=%b data=%h want set=%h way=%h mask=%b data=%h",
                     w_set, w_way, w_mask, w_data, e.set, e.way, e.mask, e.data);
          end
        end
      end else if (w_en !== 1'b0 || w_mask !== 2'b00 || w_data !== '0 || w_set !== '0 || w_way !== '0) begin
        errors++;
        $display("FAIL idle_write_outputs got en=%b set=%h way=%h mask=%b want all 0", w_en, w_set, w_way, w_mask);
      end
      if (done_valid === 1'b1) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got id=%0d want no done", done_id);
        end else begin
          eid = dq.pop_front();
          if (done_id !== eid) begin
            errors++;
            $display("FAIL done_id got %0d want %0d", done_id, eid);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_req(3'd1, 6'h01, 2'd1);
    drive_beat(3'd1, 64'h1);
    wr_stall = 1'b0;
    step();
    step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    checks++; if (beat_ready !== 1'b0) begin errors++; $display("FAIL rst_beat_ready got %b want 0", beat_ready); end
    checks++; if (done_valid !== 1'b0 || done_id !== '0) begin errors++; $display("FAIL rst_done got %b/%0d want 0/0", done_valid, done_id); end
    checks++; if (err_beat !== 1'b0) begin errors++; $display("FAIL rst_err_beat got %b want 0", err_beat); end
    checks++; if (free_cnt !== 2'(ENTRIES)) begin errors++; $display("FAIL rst_free_cnt got %0d want %0d", free_cnt, ENTRIES); end
    idle_inputs();
    rst = 1'b0;
    step();
    checks++; if (req_ready !== 1'b1 || beat_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b%b want 11", req_ready, beat_ready); end
  endtask

  task automatic test_single();
    logic [63:0] b [4];
    b[0] = 64'h1111_1111_1111_1111; b[1] = 64'h2222_2222_2222_2222;
    b[2] = 64'h3333_3333_3333_3333; b[3] = 64'h4444_4444_4444_4444;
    drive_req(3'd3, 6'h15, 2'd2);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_req_ready got %b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(3'd3, b[i]);
      if (i == 1) wq.push_back('{6'h15, 2'd2, 2'b01, {128'd0, b[1], b[0]}});
      if (i == 3) begin
        wq.push_back('{6'h15, 2'd2, 2'b10, {b[3], b[2], 128'd0}});
        dq.push_back(3'd3);
      end
      step();
      if (i == 1 || i == 3) begin
        checks++;
        if (w_en !== 1'b1 || w_mask !== (i == 1 ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL single_write_timing beat%0d got en=%b mask=%b", i, w_en, w_mask);
        end
      end
    end
    beat_valid = 1'b0;
    step();
    checks++; if (done_valid !== 1'b1 || done_id !== 3'd3) begin errors++; $display("FAIL single_done got %b/%0d want 1/3", done_valid, done_id); end
    step();
    checks++; if (free_cnt !== 2'd2) begin errors++; $display("FAIL single_free_cnt got %0d want 2", free_cnt); end
    checks++; if (wq.size() != 0 || dq.size() != 0) begin errors++; $display("FAIL single_pending got %0d/%0d want 0/0", wq.size(), dq.size()); end
  endtask

  task automatic test_stall_merge();
    logic [63:0] b [4];
    b[0] = 64'hA0A0_0000_0000_0001; b[1] = 64'hA1A1_0000_0000_0002;
    b[2] = 64'hA2A2_0000_0000_0003; b[3] = 64'hA3A3_0000_0000_0004;
    drive_req(3'd5, 6'h2A, 2'd1);
    step();
    req_valid = 1'b0;
    wr_stall  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(3'd5, b[i]);
      step();
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL stall_no_write beat%0d got %b want 0", i, w_en); end
    end
    beat_valid = 1'b0;
    step();
    checks++; if (w_en !== 1'b0 || done_valid !== 1'b0) begin errors++; $display("FAIL stall_hold got en=%b done=%b want 0/0", w_en, done_valid); end
    wq.push_back('{6'h2A, 2'd1, 2'b11, {b[3], b[2], b[1], b[0]}});
    dq.push_back(3'd5);
    wr_stall = 1'b0;
    #1;
    checks++; if (w_en !== 1'b1 || w_mask !== 2'b11) begin errors++; $display("FAIL stall_merge got en=%b mask=%b want 1/11", w_en, w_mask); end
    step();
    checks++; if (done_valid !== 1'b1 || done_id !== 3'd5 || w_en !== 1'b0) begin
      errors++; $display("FAIL stall_done got done=%b id=%0d en=%b want 1/5/0", done_valid, done_id, w_en);
    end
    step();
    checks++; if (wq.size() != 0 || dq.size() != 0 || free_cnt !== 2'd2) begin
      errors++; $display("FAIL stall_end got q=%0d/%0d free=%0d want 0/0/2", wq.size(), dq.size(), free_cnt);
    end
  endtask

  task automatic test_interleave();
    logic [63:0] a [4];
    logic [63:0] c [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = 64'hAAAA_0000_0000_0000 | 64'(i);
      c[i] = 64'hCCCC_0000_0000_0000 | 64'(i);
    end
    do_reset();
    drive_req(3'd1, 6'h01, 2'd1);
    step();
    drive_req(3'd2, 6'h3C, 2'd3);
    step();
    req_valid = 1'b0;
    checks++; if (free_cnt !== 2'd0) begin errors++; $display("FAIL inter_free_busy got %0d want 0", free_cnt); end
    wr_stall = 1'b1;
    drive_beat(3'd1, a[0]); step();
    drive_beat(3'd2, c[0]); step();
    drive_beat(3'd1, a[1]); step();
    drive_beat(3'd2, c[1]); step();
    // both low halves pending; pointer at 0 grants id 1 first
    wq.push_back('{6'h01, 2'd1, 2'b01, {128'd0, a[1], a[0]}});
    wr_stall = 1'b0;
    drive_beat(3'd1, a[2]);
    #1;
    checks++; if (w_en !== 1'b1 || w_set !== 6'h01) begin errors++; $display("FAIL inter_grant0 got en=%b set=%h want 1/01", w_en, w_set); end
    step();
    wr_stall = 1'b1;
    drive_beat(3'd2, c[2]); step();
    drive_beat(3'd1, a[3]); step();
    drive_beat(3'd2, c[3]); step();
    // pointer moved past id 1, so id 2 wins despite id 1 also pending
    wq.push_back('{6'h3C, 2'd3, 2'b11, {c[3], c[2], c[1], c[0]}});
    wq.push_back('{6'h01, 2'd1, 2'b10, {a[3], a[2], 128'd0}});
    dq.push_back(3'd2);
    dq.push_back(3'd1);
    wr_stall   = 1'b0;
    beat_valid = 1'b0;
    #1;
    checks++; if (w_set !== 6'h3C || w_mask !== 2'b11) begin errors++; $display("FAIL inter_grant1 got set=%h mask=%b want 3c/11", w_set, w_mask); end
    step();
    checks++; if (w_set !== 6'h01 || w_mask !== 2'b10 || done_id !== 3'd2) begin
      errors++; $display("FAIL inter_grant2 got set=%h mask=%b done_id=%0d want 01/10/2", w_set, w_mask, done_id);
    end
    step();
    checks++; if (done_valid !== 1'b1 || done_id !== 3'd1) begin errors++; $display("FAIL inter_done1 got %b/%0d want 1/1", done_valid, done_id); end
    step();
    checks++; if (free_cnt !== 2'd2 || wq.size() != 0 || dq.size() != 0) begin
      errors++; $display("FAIL inter_end got free=%0d q=%0d/%0d want 2/0/0", free_cnt, wq.size(), dq.size());
    end
  endtask

  task automatic test_full_dup();
    logic [63:0] d [4];
    logic saw_done;
    logic ok;
    for (int i = 0; i < 4; i++) d[i] = 64'h4D4D_0000_0000_0000 | 64'(i);
    drive_req(3'd4, 6'h10, 2'd0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_first_ready got %b want 1", req_ready); end
    step();
    drive_req(3'd4, 6'h11, 2'd1);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL dup_id_ready got %b want 0", req_ready); end
    step();
    drive_req(3'd6, 6'h12, 2'd2);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_second_ready got %b want 1", req_ready); end
    step();
    drive_req(3'd7, 6'h13, 2'd3);
    #1;
    checks++; if (req_ready !== 1'b0 || free_cnt !== 2'd0) begin errors++; $display("FAIL full_ready got %b free=%0d want 0/0", req_ready, free_cnt); end
    for (int i = 0; i < 4; i++) begin
      drive_beat(3'd4, d[i]);
      if (i == 1) wq.push_back('{6'h10, 2'd0, 2'b01, {128'd0, d[1], d[0]}});
      if (i == 3) begin
        wq.push_back('{6'h10, 2'd0, 2'b10, {d[3], d[2], 128'd0}});
        dq.push_back(3'd4);
      end
      step();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_hold beat%0d got %b want 0", i, req_ready); end
    end
    beat_valid = 1'b0;
    saw_done = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      checks++;
      if (saw_done) begin
        if (req_ready !== 1'b1) begin errors++; $display("FAIL full_release got %b want 1", req_ready); end
        ok = 1'b1;
      end else begin
        if (req_ready !== 1'b0) begin errors++; $display("FAIL full_early_ready got %b want 0", req_ready); end
        if (done_valid === 1'b1) saw_done = 1'b1;
        step();
      end
    end
    if (!ok) begin checks++; errors++; $display("FAIL full_timeout got no done want done within 10 cycles"); end
    step();
    req_valid = 1'b0;
    checks++; if (free_cnt !== 2'd0 || wq.size() != 0 || dq.size() != 0) begin
      errors++; $display("FAIL full_end got free=%0d q=%0d/%0d want 0/0/0", free_cnt, wq.size(), dq.size());
    end
  endtask

  task automatic test_err();
    logic [63:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = 64'hE0E0_0000_0000_0000 | 64'(i + 16);
    do_reset();
    drive_req(3'd2, 6'h07, 2'd3);
    drive_beat(3'd2, 64'hDEAD_BEEF_DEAD_BEEF);
    step();
    req_valid = 1'b0;
    drive_beat(3'd5, 64'hBAD0_BAD0_BAD0_BAD0);
    checks++; if (err_beat !== 1'b1) begin errors++; $display("FAIL err_same_cycle got %b want 1", err_beat); end
    step();
    wr_stall = 1'b1;
    drive_beat(3'd2, d[0]);
    checks++; if (err_beat !== 1'b1) begin errors++; $display("FAIL err_unknown_id got %b want 1", err_beat); end
    step();
    drive_beat(3'd2, d[1]);
    checks++; if (err_beat !== 1'b0) begin errors++; $display("FAIL err_good_beat got %b want 0", err_beat); end
    step();
    drive_beat(3'd2, d[2]); step();
    drive_beat(3'd2, d[3]); step();
    drive_beat(3'd2, 64'hFFFF_0000_FFFF_0000);
    step();
    beat_valid = 1'b0;
    checks++; if (err_beat !== 1'b1 || w_en !== 1'b0) begin errors++; $display("FAIL err_fifth_beat got err=%b en=%b want 1/0", err_beat, w_en); end
    wq.push_back('{6'h07, 2'd3, 2'b11, {d[3], d[2], d[1], d[0]}});
    dq.push_back(3'd2);
    wr_stall = 1'b0;
    step();
    checks++; if (done_valid !== 1'b1 || done_id !== 3'd2) begin errors++; $display("FAIL err_done got %b/%0d want 1/2", done_valid, done_id); end
    step();
    checks++; if (wq.size() != 0 || dq.size() != 0) begin errors++; $display("FAIL err_pending got %0d/%0d want 0/0", wq.size(), dq.size()); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = 64'h5A5A_0000_0000_0000 | 64'(i + 32);
    do_reset();
    drive_req(3'd1, 6'h3F, 2'd0);
    step();
    req_valid = 1'b0;
    wr_stall  = 1'b1;
    drive_beat(3'd1, 64'h0101_0101_0101_0101); step();
    drive_beat(3'd1, 64'h0202_0202_0202_0202); step();
    beat_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0 || beat_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b%b want 00", req_ready, beat_ready); end
    step();
    checks++; if (free_cnt !== 2'(ENTRIES) || w_en !== 1'b0 || done_valid !== 1'b0 || err_beat !== 1'b0) begin
      errors++; $display("FAIL mid_rst_state got free=%0d en=%b done=%b err=%b want 2/0/0/0", free_cnt, w_en, done_valid, err_beat);
    end
    rst      = 1'b0;
    wr_stall = 1'b0;
    step();
    step();
    checks++; if (w_en !== 1'b0 || done_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_discard got en=%b done=%b want 0/0", w_en, done_valid); end
    drive_req(3'd1, 6'h0A, 2'd3);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(3'd1, d[i]);
      if (i == 1) wq.push_back('{6'h0A, 2'd3, 2'b01, {128'd0, d[1], d[0]}});
      if (i == 3) begin
        wq.push_back('{6'h0A, 2'd3, 2'b10, {d[3], d[2], 128'd0}});
        dq.push_back(3'd1);
      end
      step();
    end
    beat_valid = 1'b0;
    step();
    checks++; if (done_valid !== 1'b1 || done_id !== 3'd1) begin errors++; $display("FAIL mid_refill_done got %b/%0d want 1/1", done_valid, done_id); end
    step();
    checks++; if (free_cnt !== 2'd2 || wq.size() != 0 || dq.size() != 0) begin
      errors++; $display("FAIL mid_end got free=%0d q=%0d/%0d want 2/0/0", free_cnt, wq.size(), dq.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    req_id = '0; req_set = '0; req_way = '0;
    beat_id = '0; beat_data = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_stall_merge();
    test_interleave();
    test_full_dup();
    test_err();
    test_reset_mid();
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
